// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: NOP bubble encoding,
// default reset PC and the fetch controller state enumeration.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h00000013;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: loads either the redirect target or PC+4
// (wrapping modulo 2^XLEN) when load_en is high; synchronous reset to RESET_PC.
module pc_reg
  import fetch_pkg::*;
#(
  parameter int               XLEN     = 64,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_en,
  input  logic            redirect,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_next;

  // Next-value mux: redirect target wins over sequential advance
  always_comb begin
    pc_next = redirect ? target : pc + XLEN'(4);
  end

  // PC state, held whenever the controller does not enable a load
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (load_en) begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, BOOT/RUN/HALT controller and the
// IF/ID pipeline register. Optional feature macro FETCH_MISALIGN_TRAP_EN:
// when defined a misaligned redirect target halts fetch and raises fault;
// otherwise the target's low two bits are cleared and fault stays 0.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int               XLEN     = 64,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_instr,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr,
  output logic            if_id_valid,
  output logic            fault
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] aligned_target;
  logic            trap;
  logic            pc_load_en;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q;
  assign trap  = redirect && (redirect_target[1:0] != 2'b00);
  assign fault = fault_q;
`else
  assign trap  = 1'b0;
  assign fault = 1'b0;
`endif

  // Word-align the target; in the trap build a misaligned target never loads
  assign aligned_target = redirect_target & ~XLEN'(3);
  assign imem_addr      = pc;

  // PC moves only while running: on a redirect (unless trapping) or when not stalled
  always_comb begin
    pc_load_en = (state == RUN) && !trap && (redirect || !stall);
  end

  pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .reset    (reset),
    .load_en  (pc_load_en),
    .redirect (redirect),
    .target   (aligned_target),
    .pc       (pc)
  );

  // Controller FSM and IF/ID register; priority reset > redirect > stall > advance
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BOOT;
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state <= RUN;
        end
        RUN: begin
          if (redirect) begin
            if (trap) begin
              state       <= HALT;
              if_id_valid <= 1'b0;
            end else begin
              if_id_instr <= NOP_INSTR;
              if_id_valid <= 1'b0;
            end
          end else if (!stall) begin
            if_id_pc    <= pc;
            if_id_instr <= imem_instr;
            if_id_valid <= 1'b1;
          end
        end
        HALT: begin
          if_id_valid <= 1'b0;
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Sticky fault flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if (state == RUN && trap) begin
      fault_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// stall/redirect/reset traffic, compared against a cycle-level reference model.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam int          XLEN   = 64;
  localparam logic [63:0] RST_PC = 64'h0;
  localparam logic [31:0] NOP    = 32'h00000013;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_instr;
  logic            stall;
  logic            redirect;
  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] if_id_pc;
  logic [31:0]     if_id_instr;
  logic            if_id_valid;
  logic            fault;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [63:0] m_pc, m_ifpc;
  logic [31:0] m_instr;
  bit          m_valid, m_fault, m_booting, m_halted;

  always #5 clk = ~clk;

  // Instruction memory: address 0 holds 32'h00700013, other words unique
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'h00700013 ^ {a[29:0], 2'b00};
  endfunction

  assign imem_instr = mem_word(imem_addr);

  fetch_stage #(
    .XLEN     (XLEN),
    .RESET_PC (RST_PC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .if_id_pc        (if_id_pc),
    .if_id_instr     (if_id_instr),
    .if_id_valid     (if_id_valid),
    .fault           (fault)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare #1 later
  task automatic step(input bit r, input bit st, input bit rd, input logic [63:0] tgt);
    reset           = r;
    stall           = st;
    redirect        = rd;
    redirect_target = tgt;
    @(posedge clk);
    if (r) begin
      m_pc = RST_PC; m_ifpc = '0; m_instr = NOP;
      m_valid = 0; m_fault = 0; m_booting = 1; m_halted = 0;
    end else if (m_booting) begin
      m_booting = 0;
    end else if (m_halted) begin
      m_valid = 0;
    end else if (rd) begin
      if (TRAP_EN && tgt[1:0] != 2'b00) begin
        m_halted = 1; m_valid = 0; m_fault = 1;
      end else begin
        m_pc = {tgt[63:2], 2'b00}; m_instr = NOP; m_valid = 0;
      end
    end else if (!st) begin
      m_ifpc = m_pc; m_instr = mem_word(m_pc); m_valid = 1;
      m_pc = m_pc + 64'd4;
    end
    #1;
    chk("imem_addr",   imem_addr,   m_pc);
    chk("if_id_pc",    if_id_pc,    m_ifpc);
    chk("if_id_instr", 64'(if_id_instr), 64'(m_instr));
    chk("if_id_valid", 64'(if_id_valid), 64'(m_valid));
    chk("fault",       64'(fault),  64'(m_fault));
  endtask

  initial begin
    logic [63:0] tgt;
    bit r, st, rd;
    reset = 1; stall = 0; redirect = 0; redirect_target = '0;
    m_pc = RST_PC; m_ifpc = '0; m_instr = NOP;
    m_valid = 0; m_fault = 0; m_booting = 1; m_halted = 0;

    // Reset and boot, then sequential fetch 0,4,8
    step(1, 0, 0, 64'd0);
    step(1, 1, 1, 64'd100);
    step(0, 0, 0, 64'd0);
    step(0, 0, 0, 64'd0);
    chk("first_instr", 64'(if_id_instr), 64'h00700013);
    step(0, 0, 0, 64'd0);
    // Stall two cycles at PC=8, then advance
    step(0, 1, 0, 64'd0);
    step(0, 1, 0, 64'd0);
    chk("stall_hold_addr", imem_addr, 64'd8);
    step(0, 0, 0, 64'd0);
    step(0, 0, 0, 64'd0);
    // Redirect at PC=16 to 44
    chk("pre_redirect_pc", imem_addr, 64'd16);
    step(0, 0, 1, 64'd44);
    step(0, 0, 0, 64'd0);
    chk("redirect_ifpc", if_id_pc, 64'd44);
    // Redirect with stall to 32
    step(0, 1, 1, 64'd32);
    step(0, 0, 0, 64'd0);
    // PC wrap at top of address space
    step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 0, 0, 64'd0);
    chk("wrap_addr", imem_addr, 64'd0);
    step(0, 0, 0, 64'd0);
    // Misaligned redirect target
    step(0, 0, 1, 64'd34);
    step(0, 0, 0, 64'd0);
    step(0, 1, 1, 64'd64);
    step(0, 0, 0, 64'd0);
    // Reset during a stall and during a redirect
    step(1, 1, 0, 64'd0);
    step(0, 0, 0, 64'd0);
    step(0, 0, 0, 64'd0);
    step(0, 0, 0, 64'd0);
    step(1, 0, 1, 64'd200);
    step(0, 0, 0, 64'd0);
    step(0, 0, 0, 64'd0);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      r   = ($urandom % 50) == 0;
      st  = ($urandom % 4) == 0;
      rd  = ($urandom % 6) == 0;
      tgt = {$urandom, $urandom};
      if (($urandom % 8) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | (tgt & 64'hF);
      if (($urandom % 4) != 0) tgt[1:0] = 2'b00;
      step(r, st, rd, tgt);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
